// File: rtl/act_quant_pack.sv
// Activation quantizer/packer: saturates (optionally ReLU'd) elements to int8,
// packs four lanes per 32-bit word and buffers the words in a small FIFO.
module act_quant_pack #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic signed [31:0]            data_in,
  input  logic                          relu_en,
  input  logic                          flush,
  input  logic                          out_ready,
  input  logic                          clear_overflow,
  output logic                          out_valid,
  output logic [31:0]                   out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  function automatic logic signed [7:0] quantize(input logic signed [31:0] d,
                                                 input logic relu);
    if (relu && (d < 32'sd0))  return 8'sd0;
    if (d > 32'sd127)          return 8'sd127;
    if (d < -32'sd128)         return -8'sd128;
    return d[7:0];
  endfunction

  logic        [1:0]    r_lane_cnt;
  logic        [31:0]   r_stage;
  logic        [31:0]   r_mem [FIFO_DEPTH];
  logic        [AW-1:0] r_wptr;
  logic        [AW-1:0] r_rptr;
  logic        [CW-1:0] r_count;
  logic                 r_overflow;

  logic signed [7:0]    w_q;
  logic        [31:0]   w_word;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_wr_en;
  logic                 w_ovf;

  // Quantize + merge the current element into the word being assembled
  always_comb begin
    w_q    = quantize(data_in, relu_en);
    w_word = r_stage;
    if (valid_in) w_word[{r_lane_cnt, 3'b000} +: 8] = w_q;
  end

  assign w_push  = (valid_in && (r_lane_cnt == 2'd3)) ||
                   (flush && ((r_lane_cnt != 2'd0) || valid_in));
  assign w_pop   = (r_count != '0) && out_ready;
  assign w_full  = (r_count == FULL_CNT);
  // A pop on the same edge frees the slot, so a full FIFO still accepts
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_ovf   = w_push && w_full && !w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lane_cnt <= 2'd0;
      r_stage    <= '0;
    end else if (w_push) begin
      r_lane_cnt <= 2'd0;
      r_stage    <= '0;
    end else if (valid_in) begin
      r_lane_cnt <= r_lane_cnt + 2'd1;
      r_stage    <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wptr] <= w_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + AW'(1);
      if (w_pop)   r_rptr <= r_rptr + AW'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A fresh drop outranks a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_overflow <= 1'b0;
    else if (w_ovf)          r_overflow <= 1'b1;
    else if (clear_overflow) r_overflow <= 1'b0;
  end

  assign out_valid  = (r_count != '0);
  assign out_data   = out_valid ? r_mem[r_rptr] : 32'd0;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_act_quant_pack.sv
// Directed bench for act_quant_pack: vector table for single-cycle behaviour,
// hand-written sequences for backpressure, overflow and reset corners.
module tb_act_quant_pack;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic signed [31:0] data_in;
  logic              relu_en;
  logic              flush;
  logic              out_ready;
  logic              clear_overflow;
  logic              out_valid;
  logic [31:0]       out_data;
  logic [2:0]        fifo_count;
  logic              overflow;

  int total = 0;
  int bad   = 0;

  act_quant_pack #(.FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .relu_en        (relu_en),
    .flush          (flush),
    .out_ready      (out_ready),
    .clear_overflow (clear_overflow),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    int          d;
    logic        relu;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    int          ec;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input int d, input logic relu, input logic fl,
                     input logic rdy, input logic clr);
    valid_in       = v;
    data_in        = d;
    relu_en        = relu;
    flush          = fl;
    out_ready      = rdy;
    clear_overflow = clr;
    @(posedge clk);
    #1;
    valid_in       = 1'b0;
    flush          = 1'b0;
    clear_overflow = 1'b0;
  endtask

  function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  initial begin
    reset = 1'b1; valid_in = 0; data_in = 0; relu_en = 0; flush = 0;
    out_ready = 0; clear_overflow = 0;

    vecs[0]  = '{1, 5,    0, 0, 1, 0, 32'h0,        0};
    vecs[1]  = '{1, -3,   0, 0, 1, 0, 32'h0,        0};
    vecs[2]  = '{1, 200,  0, 0, 1, 0, 32'h0,        0};
    vecs[3]  = '{1, -300, 0, 0, 1, 1, 32'h807FFD05, 1};
    vecs[4]  = '{0, 0,    0, 0, 1, 0, 32'h0,        0};
    vecs[5]  = '{1, -7,   1, 0, 1, 0, 32'h0,        0};
    vecs[6]  = '{1, 12,   1, 0, 1, 0, 32'h0,        0};
    vecs[7]  = '{1, -1,   1, 0, 1, 0, 32'h0,        0};
    vecs[8]  = '{1, 127,  1, 0, 1, 1, 32'h7F000C00, 1};
    vecs[9]  = '{0, 0,    0, 0, 1, 0, 32'h0,        0};
    vecs[10] = '{1, 1,    0, 0, 1, 0, 32'h0,        0};
    vecs[11] = '{1, 2,    0, 0, 1, 0, 32'h0,        0};
    vecs[12] = '{0, 0,    0, 1, 1, 1, 32'h00000201, 1};
    vecs[13] = '{0, 0,    0, 1, 1, 0, 32'h0,        0};
    vecs[14] = '{1, 9,    0, 0, 1, 0, 32'h0,        0};
    vecs[15] = '{1, 10,   0, 1, 1, 1, 32'h00000A09, 1};
    vecs[16] = '{1, -5,   0, 1, 1, 1, 32'h000000FB, 1};
    vecs[17] = '{0, 0,    0, 0, 1, 0, 32'h0,        0};
    vecs[18] = '{1, 1000, 1, 1, 1, 1, 32'h0000007F, 1};
    vecs[19] = '{0, 0,    0, 0, 1, 0, 32'h0,        0};

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;

    // Table: packing, ReLU, saturation, flush
    for (int i = 0; i < 20; i++) begin
      cyc(vecs[i].v, vecs[i].d, vecs[i].relu, vecs[i].fl, vecs[i].rdy, 1'b0);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].ed);
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].ec));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'd0);
    end

    // Backpressure: 20 elements into a 4-deep FIFO, head must hold still
    for (int n = 1; n <= 20; n++) begin
      cyc(1'b1, n, 1'b0, 1'b0, 1'b0, 1'b0);
      if (n >= 4) chk($sformatf("bp_head_%0d", n), out_data, 32'h04030201);
    end
    chk("bp_count", 32'(fifo_count), 32'd4);
    chk("bp_ovf", 32'(overflow), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("drain%0d_data", k), out_data, pack(4*k+1, 4*k+2, 4*k+3, 4*k+4));
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_count", 32'(fifo_count), 32'd0);
    chk("drain_ovf_sticky", 32'(overflow), 32'd1);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO with a pop on the edge of the pushing 4th lane
    for (int n = 30; n < 46; n++) cyc(1'b1, n, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(fifo_count), 32'd4);
    for (int n = 46; n < 49; n++) cyc(1'b1, n, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 49, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("simul_count", 32'(fifo_count), 32'd4);
    chk("simul_ovf", 32'(overflow), 32'd0);
    chk("simul_head", out_data, pack(34, 35, 36, 37));
    // Drop while clear_overflow is high: the drop wins
    for (int n = 50; n < 53; n++) cyc(1'b1, n, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 53, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_beats_clear", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("order%0d", k), out_data, pack(34+4*k, 35+4*k, 36+4*k, 37+4*k));
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("order_empty", 32'(out_valid), 32'd0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared2", 32'(overflow), 32'd0);

    // Reset mid-word with a buffered word present
    for (int n = 60; n < 64; n++) cyc(1'b1, n, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(fifo_count), 32'd1);
    cyc(1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_count", 32'(fifo_count), 32'd0);
    chk("async_rst_data", out_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 0; n < 4; n++) cyc(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_count", 32'(fifo_count), 32'd1);
    chk("post_rst_data", out_data, 32'h01010101);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_empty", 32'(fifo_count), 32'd0);
    chk("post_rst_nvalid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/act_quant_pack.md
ACT_QUANT_PACK -- requirements
Module: act_quant_pack

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: number of packed 32-bit words buffered; power of two, 2..16.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port valid_in, input, 1: data_in is a valid element this cycle; no backpressure to the upstream normalizer.
REQ-005 SHALL have port data_in, input, 32 signed: normalized element from the upstream normalizer data_out.
REQ-006 SHALL have port relu_en, input, 1: apply ReLU before saturation; sampled per element with valid_in.
REQ-007 SHALL have port flush, input, 1: emit a partially filled word.
REQ-008 SHALL have port out_ready, input, 1: the consumer accepts out_data this cycle.
REQ-009 SHALL have port clear_overflow, input, 1: clears the sticky overflow flag.
REQ-010 SHALL have port out_valid, output, 1: the FIFO head word is valid.
REQ-011 SHALL have port out_data, output, 32: packed word of four int8 lanes; lane0 is bits [7:0].
REQ-012 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1: words currently buffered.
REQ-013 SHALL have port overflow, output, 1: sticky flag; a packed word was dropped.

Function
REQ-014 SHALL quantize each element combinationally: if relu_en and data_in<0 then 0; else clamp data_in to [-128,127]; take the result as 8-bit two's complement.
REQ-015 SHALL keep a lane counter 0..3 and a 32-bit staging register.
- Each valid_in writes the quantized byte into lane lane_cnt.
- Each valid_in then increments lane_cnt, modulo 4.
REQ-016 SHALL push the word into the FIFO on the rising edge where valid_in arrives with lane_cnt=3: {q3,q2,q1,q0}, lane3 taken from the current data_in.
- lane_cnt returns to 0.
- The staging register clears to 0.
REQ-017 SHALL push a partial word on flush when lane_cnt>0 or valid_in=1.
- The current element, if valid, is included.
- Unfilled lanes are 0.
- lane_cnt becomes 0.
REQ-018 SHALL do nothing on flush when lane_cnt=0 and valid_in=0: no push.
REQ-019 SHALL make out_valid equal to (fifo_count != 0).
- out_data shows the oldest word, taken directly from FIFO storage.
- Latency from the pushing edge to out_valid is 1 cycle when the FIFO was empty.
REQ-020 SHALL pop the head word on the edge where out_valid && out_ready.
- out_ready while empty has no effect.
REQ-021 SHALL behave on a simultaneous push and pop as follows:
- Both occur.
- fifo_count is unchanged.
- This holds when the FIFO is full.
REQ-022 SHALL handle a push when full with no pop as follows:
- The new word is discarded.
- FIFO contents and count are unchanged.
- overflow is set on that edge.
REQ-023 SHALL clear overflow only by clear_overflow; a same-cycle new overflow event wins, and overflow stays 1.
REQ-024 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL use circular read and write pointers that wrap modulo FIFO_DEPTH; full is fifo_count==FIFO_DEPTH.

Reset
REQ-026 SHALL force the following while reset is asserted, asynchronously:
- lane_cnt=0.
- Staging register=0.
- FIFO pointers and fifo_count=0.
- out_valid=0.
- out_data=0.
- overflow=0.
REQ-027 SHALL discard any partial word and all buffered words on reset asserted mid-operation, and emit none after release.
REQ-028 SHALL accept valid_in on the first rising edge after reset deasserts.

Verification
REQ-029 Packing: out_ready=1, relu_en=0, data_in 5, -3, 200, -300 on 4 consecutive cycles -> 1 cycle after the 4th edge out_valid=1, out_data=0x807FFD05.
REQ-030 ReLU: relu_en=1, inputs -7, 12, -1, 127 -> out_data=0x7F000C00.
REQ-031 Flush: inputs 1, 2 then flush with valid_in=0 -> one word 0x00000201 and lane_cnt=0; a second flush alone -> no push.
REQ-032 Backpressure/overflow: FIFO_DEPTH=4, out_ready=0, 20 elements -> fifo_count=4 and overflow=1; words 1-4 drain in order when out_ready=1; clear_overflow -> overflow=0.
REQ-033 Full with simultaneous pop: FIFO full, out_ready=1 on the edge of a 4th-lane push -> count stays 4, no overflow, order preserved.
REQ-034 Reset mid-word: 2 elements, then reset for 1 cycle, then 4 elements 1,1,1,1 -> the only word out is 0x01010101.
